uart_mem_loader: RTL and testbench

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader_pkg.sv | 22 ++
 rtl/uart_mem_loader_rx.sv | 99 +++++++++
 rtl/uart_mem_loader.sv | 145 ++++++++++++++
 tb/tb_uart_mem_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared constants and state encodings for the UART memory loader.
// The frame command byte and both FSM encodings live here so bench and RTL agree.
package uart_mem_loader_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_DATA,
      ST_SUM
   } ld_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_mem_loader_rx.sv
// 8N1 UART receiver: two-flop synchroniser, midpoint sampling, one-cycle
// valid or framing-error strobe at the stop-bit midpoint.
module uart_rx
   import uart_mem_loader_pkg::*;
#(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int DIV  = CLOCK_RATE / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);

   logic          rx_meta, rx_sync, rx_prev;
   rx_state_t     state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    bit_idx, bit_d;
   logic [7:0]    shift, shift_d, data_d;
   logic          valid_d, ferr_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         state     <= state_d;
         cnt       <= cnt_d;
         bit_idx   <= bit_d;
         shift     <= shift_d;
         data      <= data_d;
         valid     <= valid_d;
         frame_err <= ferr_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt + CW'(1);
      bit_d   = bit_idx;
      shift_d = shift;
      data_d  = data;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev && !rx_sync) state_d = RX_START;
         end
         RX_START: begin
            // A low that is gone by mid start bit was a glitch, not a start.
            if (cnt == CW'(HALF - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == CW'(DIV - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift[7:1]};
               bit_d   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == CW'(DIV - 1)) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (rx_sync) begin
                  valid_d = 1'b1;
                  data_d  = shift;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_mem_loader.sv
// Frame parser: 'W', addr[4], len[2] (words), data[4*len], checksum.
// Writes each assembled word to memory; flags range, checksum, framing, timeout.
module uart_mem_loader
   import uart_mem_loader_pkg::*;
#(
   parameter int          CLOCK_RATE     = 100_000_000,
   parameter int          BAUD_RATE      = 115200,
   parameter logic [31:0] MEM_SIZE       = 32'he000,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rx,
   output logic        mem_write,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   output logic        mem_wgrubby,
   output logic [31:0] mem_addr,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [7:0]    rx_data;
   logic          rx_valid, rx_ferr;
   ld_state_t     state, state_d;
   logic [1:0]    bcnt;
   logic [7:0]    len_lo;
   logic [15:0]   words;
   logic [31:0]   addr, waddr;
   logic [23:0]   wbuf;
   logic [7:0]    sum;
   logic [TW-1:0] tcnt;
   logic          timeout;

   uart_rx #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) u_rx (
      .clk       (clk),
      .rstn      (rstn),
      .rx        (rx),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr)
   );

   assign busy        = (state != ST_IDLE);
   assign mem_wgrubby = 1'b0;
   assign waddr       = {addr[31:2], 2'b00};
   assign timeout     = busy && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (rx_ferr || timeout) begin
         state_d = ST_IDLE;
      end else if (rx_valid) begin
         case (state)
            ST_IDLE: if (rx_data == CMD_WRITE) state_d = ST_ADDR;
            ST_ADDR: if (bcnt == 2'd3) state_d = ST_LEN;
            ST_LEN:  if (bcnt == 2'd1) state_d = ({rx_data, len_lo} == 16'd0) ? ST_SUM : ST_DATA;
            ST_DATA: if (bcnt == 2'd3 && words == 16'd1) state_d = ST_SUM;
            ST_SUM:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bcnt      <= '0;
         len_lo    <= '0;
         words     <= '0;
         addr      <= '0;
         wbuf      <= '0;
         sum       <= '0;
         tcnt      <= '0;
         mem_write <= 1'b0;
         mem_wmask <= '0;
         mem_wdata <= '0;
         mem_addr  <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_write <= 1'b0;
         done      <= 1'b0;
         if (!busy || rx_valid) tcnt <= '0;
         else                   tcnt <= tcnt + TW'(1);
         if (rx_ferr || timeout) error <= 1'b1;
         if (rx_valid) begin
            case (state)
               ST_IDLE: begin
                  if (rx_data == CMD_WRITE) begin
                     error <= 1'b0;
                     sum   <= '0;
                     bcnt  <= '0;
                  end
               end
               ST_ADDR: begin
                  addr[{bcnt, 3'b000} +: 8] <= rx_data;
                  bcnt <= bcnt + 2'd1;
               end
               ST_LEN: begin
                  if (bcnt == 2'd0) begin
                     len_lo <= rx_data;
                     bcnt   <= 2'd1;
                  end else begin
                     words <= {rx_data, len_lo};
                     bcnt  <= 2'd0;
                  end
               end
               ST_DATA: begin
                  sum  <= sum + rx_data;
                  bcnt <= bcnt + 2'd1;
                  case (bcnt)
                     2'd0: wbuf[7:0]   <= rx_data;
                     2'd1: wbuf[15:8]  <= rx_data;
                     2'd2: wbuf[23:16] <= rx_data;
                     default: begin
                        // Last byte of the word: issue (or refuse) the write next cycle.
                        mem_addr  <= waddr;
                        mem_wdata <= {rx_data, wbuf};
                        mem_wmask <= 4'b1111;
                        if (waddr < MEM_SIZE) mem_write <= 1'b1;
                        else                  error     <= 1'b1;
                        addr  <= waddr + 32'd4;
                        words <= words - 16'd1;
                     end
                  endcase
               end
               ST_SUM: begin
                  if (rx_data != sum) error <= 1'b1;
                  done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomised frame bench for uart_mem_loader against a frame-level reference model.
module tb_uart_mem_loader;
   import uart_mem_loader_pkg::*;

   localparam int          CR  = 8;
   localparam int          BR  = 1;
   localparam int          TO  = 200;
   localparam logic [31:0] MS  = 32'he000;
   localparam int          BIT = CR / BR;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rx;
   logic        mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic        mem_wgrubby;
   logic [31:0] mem_addr;
   logic        busy;
   logic        done;
   logic        error;

   uart_mem_loader #(
      .CLOCK_RATE(CR), .BAUD_RATE(BR), .MEM_SIZE(MS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rx          (rx),
      .mem_write   (mem_write),
      .mem_wmask   (mem_wmask),
      .mem_wdata   (mem_wdata),
      .mem_wgrubby (mem_wgrubby),
      .mem_addr    (mem_addr),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   // clock / reset
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          done_cnt = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  frame_q[$];
   logic [63:0] mon_e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every write strobe is matched against the model's expected queue
   always @(negedge clk) begin
      if (mem_write) begin
         check("write_busy", {63'd0, busy}, 64'd1);
         if (exp_q.size() == 0) begin
            check("unexp_write", {63'd0, mem_write}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("waddr",   {32'd0, mem_addr},  {32'd0, mon_e[63:32]});
            check("wdata",   {32'd0, mem_wdata}, {32'd0, mon_e[31:0]});
            check("wmask",   {60'd0, mem_wmask}, 64'hf);
            check("wgrubby", {63'd0, mem_wgrubby}, 64'd0);
         end
      end
      if (done) done_cnt++;
   end

   // driver
   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk) rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
      repeat ($urandom_range(0, 12)) @(negedge clk);
   endtask

   task automatic make_frame(input int njunk, input logic [31:0] a, input int len,
                             input bit seq, input logic [7:0] sum_xor);
      logic [7:0] s;
      logic [7:0] b;
      frame_q.delete();
      for (int j = 0; j < njunk; j++) begin
         b = 8'($urandom_range(0, 255));
         if (b == CMD_WRITE) b = 8'h00;
         frame_q.push_back(b);
      end
      frame_q.push_back(CMD_WRITE);
      for (int j = 0; j < 4; j++) frame_q.push_back(a[8*j +: 8]);
      frame_q.push_back(8'(len));
      frame_q.push_back(8'(len >> 8));
      s = 8'd0;
      for (int j = 0; j < 4 * len; j++) begin
         b = seq ? 8'(8'h11 * (j + 1)) : 8'($urandom_range(0, 255));
         s = s + b;
         frame_q.push_back(b);
      end
      frame_q.push_back(s ^ sum_xor);
   endtask

   // reference model: parse frame_q from the frame definition
   task automatic model_frame(output bit exp_err);
      int          p;
      logic [31:0] base, a, word;
      logic [15:0] len;
      logic [7:0]  s;
      p = 0;
      while (p < frame_q.size() && frame_q[p] != 8'h57) p++;
      p++;
      base = {frame_q[p+3], frame_q[p+2], frame_q[p+1], frame_q[p]} & 32'hffff_fffc;
      len  = {frame_q[p+5], frame_q[p+4]};
      p += 6;
      s = 8'd0;
      exp_err = 1'b0;
      for (int w = 0; w < int'(len); w++) begin
         word = {frame_q[p+3], frame_q[p+2], frame_q[p+1], frame_q[p]};
         s = s + frame_q[p] + frame_q[p+1] + frame_q[p+2] + frame_q[p+3];
         a = base + 32'(4 * w);
         if (a < MS) exp_q.push_back({a, word});
         else        exp_err = 1'b1;
         p += 4;
      end
      if (frame_q[p] != s) exp_err = 1'b1;
   endtask

   task automatic run_frame(input string tag);
      bit exp_err;
      int d0;
      model_frame(exp_err);
      d0 = done_cnt;
      foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
      repeat (20) @(negedge clk);
      check({tag, "_done"},    64'(done_cnt - d0), 64'd1);
      check({tag, "_error"},   {63'd0, error}, {63'd0, exp_err});
      check({tag, "_busy"},    {63'd0, busy}, 64'd0);
      check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_write"}, {63'd0, mem_write}, 64'd0);
      check({tag, "_done"},  {63'd0, done}, 64'd0);
      check({tag, "_error"}, {63'd0, error}, 64'd0);
      check({tag, "_busy"},  {63'd0, busy}, 64'd0);
      check({tag, "_mask"},  {60'd0, mem_wmask}, 64'd0);
      check({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
      check({tag, "_addr"},  {32'd0, mem_addr}, 64'd0);
      check({tag, "_grub"},  {63'd0, mem_wgrubby}, 64'd0);
   endtask

   initial begin
      int          d0;
      int          len;
      logic [31:0] a;
      logic [7:0]  sx;
      rx   = 1'b1;
      rstn = 1'b0;
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      make_frame(0, 32'h100, 2, 1'b1, 8'h00);
      run_frame("basic");
      make_frame(0, 32'h100, 2, 1'b1, 8'h64);
      run_frame("badsum");
      make_frame(0, 32'h0000_dffc, 2, 1'b1, 8'h00);
      run_frame("range");
      frame_q.delete();
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h41);
      frame_q.push_back(CMD_WRITE);
      for (int j = 0; j < 6; j++) frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
      run_frame("junk_len0");

      for (int k = 0; k < 8; k++) begin
         len = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) a = MS - 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
         else                           a = 32'($urandom_range(0, 32'hffff));
         sx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         make_frame($urandom_range(0, 2), a, len, 1'b0, sx);
         run_frame("rand");
      end

      // idle-line abort after the command byte
      d0 = done_cnt;
      send_byte(CMD_WRITE, 1'b1);
      check("to_busy_pre", {63'd0, busy}, 64'd1);
      repeat (250) @(negedge clk);
      check("to_busy",  {63'd0, busy}, 64'd0);
      check("to_error", {63'd0, error}, 64'd1);
      check("to_done",  64'(done_cnt - d0), 64'd0);

      make_frame(0, 32'h200, 1, 1'b0, 8'h00);
      run_frame("clear");

      // framing error mid-frame
      send_byte(CMD_WRITE, 1'b1);
      send_byte(8'h12, 1'b0);
      repeat (10) @(negedge clk);
      check("ferr_busy",  {63'd0, busy}, 64'd0);
      check("ferr_error", {63'd0, error}, 64'd1);

      make_frame(0, 32'h300, 1, 1'b0, 8'h00);
      run_frame("post_ferr");

      // reset after b2 of the first word
      send_byte(CMD_WRITE, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hA1, 1'b1);
      send_byte(8'hA2, 1'b1);
      send_byte(8'hA3, 1'b1);
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("midrst");
      rstn = 1'b1;
      send_byte(8'hA4, 1'b1);
      send_byte(8'h8A, 1'b1);
      repeat (20) @(negedge clk);
      check("midrst_idle", {63'd0, busy}, 64'd0);

      make_frame(1, 32'h400, 2, 1'b0, 8'h00);
      run_frame("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
